transmissor_morse: RTL and testbench

Serializes one 5-element Morse digit code, as produced by the binary-to-Morse encoder (`s1[4:0]`, one bit per element), into a timed on/off keying signal. It applies standard Morse timing: dot 1 unit, dash 3 units, 1 unit between elements and 3 units after the character. It sits directly downstream of the encoder and drives a buzzer/LED or a later line stage. A `ready`/`busy` handshake lets the encoder's consumer queue digits back-to-back.

---
 rtl/transmissor_morse_pkg.sv | 25 ++
 rtl/transmissor_morse_if.sv | 22 ++
 rtl/transmissor_morse_temporizador.sv | 27 ++
 rtl/transmissor_morse.sv | 120 ++++++++++++
 tb/tb_transmissor_morse.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/transmissor_morse_pkg.sv
// Shared Morse constants: code length, element encodings, unit multipliers, FSM states.
// Used by the transmitter and by the upstream binary-to-Morse encoder.
package transmissor_morse_pkg;

    localparam int CODE_LEN = 5;
    localparam int ELEM_W   = 3;

    localparam logic PONTO = 1'b0;
    localparam logic TRACO = 1'b1;

    localparam int MULT_PONTO = 1;
    localparam int MULT_TRACO = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MARCA  = 2'd1,
        PAUSA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

    function automatic int mult_elemento(input logic b);
        return (b == TRACO) ? MULT_TRACO : MULT_PONTO;
    endfunction

endpackage

// File: rtl/transmissor_morse_if.sv
// Digit request/keying bundle between the encoder side (master) and the transmitter (slave).
interface transmissor_morse_if;
    import transmissor_morse_pkg::*;

    logic [CODE_LEN-1:0] s1;
    logic                ready;
    logic                key;
    logic                busy;
    logic                done;
    logic [ELEM_W-1:0]   elemento;

    modport master (
        output s1, ready,
        input  key, busy, done, elemento
    );

    modport slave (
        input  s1, ready,
        output key, busy, done, elemento
    );

endinterface

// File: rtl/transmissor_morse_temporizador.sv
// Loadable down-counter; expira is high during the last cycle of a loaded interval.
// A load of N gives exactly N cycles before the interval ends; counter rests at 0.
module temporizador_morse #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] valor,
    output logic         expira
);

    logic [W-1:0] r_cont;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cont <= '0;
        end else if (load) begin
            r_cont <= valor;
        end else if (r_cont != '0) begin
            r_cont <= r_cont - W'(1);
        end
    end

    assign expira = (r_cont == W'(1));

endmodule

// File: rtl/transmissor_morse.sv
// Serializes a 5-element Morse code (msb first) into timed keying: dot U, dash 3U, gaps U / 3U.
// All outputs registered; requests are taken only while idle, including the cycle that pulses done.
module transmissor_morse
    import transmissor_morse_pkg::*;
#(
    parameter int UNIT_TICKS = 4
) (
    input  logic                clock,
    input  logic                reset,
    transmissor_morse_if.slave  bus
);

    localparam int TW = $clog2(3 * UNIT_TICKS + 1);
    localparam logic [TW-1:0] T_UNIT = TW'(UNIT_TICKS);
    localparam logic [TW-1:0] T_FIM  = TW'(3 * UNIT_TICKS);

    estado_t             r_estado, w_estado;
    logic [CODE_LEN-1:0] r_shift, w_shift;
    logic [ELEM_W-1:0]   r_elem, w_elem;
    logic                r_key, w_key;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                w_load;
    logic [TW-1:0]       w_valor;
    logic                w_expira;

    function automatic logic [TW-1:0] duracao(input logic b);
        return TW'(mult_elemento(b) * UNIT_TICKS);
    endfunction

    temporizador_morse #(.W(TW)) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .load   (w_load),
        .valor  (w_valor),
        .expira (w_expira)
    );

    // r_shift[msb] always holds the element being sent or the next one to send;
    // it advances when a mark ends so the gap already knows the next length.
    always_comb begin
        w_estado = r_estado;
        w_shift  = r_shift;
        w_elem   = r_elem;
        w_key    = r_key;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_load   = 1'b0;
        w_valor  = '0;
        case (r_estado)
            OCIOSO: begin
                if (bus.ready) begin
                    w_estado = MARCA;
                    w_shift  = bus.s1;
                    w_elem   = '0;
                    w_key    = 1'b1;
                    w_busy   = 1'b1;
                    w_load   = 1'b1;
                    w_valor  = duracao(bus.s1[CODE_LEN-1]);
                end
            end
            MARCA: begin
                if (w_expira) begin
                    w_key   = 1'b0;
                    w_load  = 1'b1;
                    w_shift = {r_shift[CODE_LEN-2:0], 1'b0};
                    if (r_elem < ELEM_W'(CODE_LEN - 1)) begin
                        w_estado = PAUSA;
                        w_valor  = T_UNIT;
                    end else begin
                        w_estado = FIM;
                        w_valor  = T_FIM;
                    end
                end
            end
            PAUSA: begin
                if (w_expira) begin
                    w_estado = MARCA;
                    w_elem   = r_elem + ELEM_W'(1);
                    w_key    = 1'b1;
                    w_load   = 1'b1;
                    w_valor  = duracao(r_shift[CODE_LEN-1]);
                end
            end
            FIM: begin
                if (w_expira) begin
                    w_estado = OCIOSO;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    w_elem   = '0;
                end
            end
            default: w_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_shift  <= '0;
            r_elem   <= '0;
            r_key    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_estado <= w_estado;
            r_shift  <= w_shift;
            r_elem   <= w_elem;
            r_key    <= w_key;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign bus.key      = r_key;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.elemento = r_elem;

endmodule

// File: tb/tb_transmissor_morse.sv
// Bench for transmissor_morse: a U=2 and a U=1 instance checked every cycle against a waveform model.
module tb_transmissor_morse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2, rst1;
    transmissor_morse_if bus2();
    transmissor_morse_if bus1();

    transmissor_morse #(.UNIT_TICKS(2)) u_dut2 (.clock(clk), .reset(rst2), .bus(bus2));
    transmissor_morse #(.UNIT_TICKS(1)) u_dut1 (.clock(clk), .reset(rst1), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: per character, build the full expected waveform as a list of (key, elemento) per cycle.
    bit [3:0] prof [2][64];
    int       t_len [2];
    int       n_cyc [2];
    bit       act [2];
    logic     e_key [2], e_busy [2], e_done [2];
    logic [2:0] e_elem [2];
    bit       started = 1'b0;

    task automatic build(input int d, input logic [4:0] code, input int u);
        int idx;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            int len;
            len = code[4-k] ? 3 * u : u;
            for (int j = 0; j < len; j++) begin prof[d][idx] = {1'b1, 3'(k)}; idx++; end
            if (k < 4)
                for (int j = 0; j < u; j++) begin prof[d][idx] = {1'b0, 3'(k)}; idx++; end
        end
        for (int j = 0; j < 3 * u; j++) begin prof[d][idx] = {1'b0, 3'd4}; idx++; end
        t_len[d] = idx;
    endtask

    task automatic mstep(input int d, input logic rst, input logic rdy, input logic [4:0] code, input int u);
        bit [3:0] p;
        if (!rst) begin
            act[d] = 1'b0;
            n_cyc[d] = 0;
        end else if ((!act[d] || n_cyc[d] > t_len[d]) && rdy) begin
            build(d, code, u);
            act[d] = 1'b1;
            n_cyc[d] = 1;
        end else if (act[d]) begin
            n_cyc[d]++;
            if (n_cyc[d] > t_len[d] + 1) act[d] = 1'b0;
        end
        if (act[d] && n_cyc[d] <= t_len[d]) begin
            p = prof[d][n_cyc[d]-1];
            e_key[d] = p[3]; e_busy[d] = 1'b1; e_done[d] = 1'b0; e_elem[d] = p[2:0];
        end else if (act[d] && n_cyc[d] == t_len[d] + 1) begin
            e_key[d] = 1'b0; e_busy[d] = 1'b0; e_done[d] = 1'b1; e_elem[d] = 3'd0;
        end else begin
            e_key[d] = 1'b0; e_busy[d] = 1'b0; e_done[d] = 1'b0; e_elem[d] = 3'd0;
        end
    endtask

    initial begin
        act[0] = 1'b0; act[1] = 1'b0; n_cyc[0] = 0; n_cyc[1] = 0; t_len[0] = 0; t_len[1] = 0;
    end

    always @(posedge clk) begin
        mstep(0, rst2, bus2.ready, bus2.s1, 2);
        mstep(1, rst1, bus1.ready, bus1.s1, 1);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("key_u2",  bus2.key,      e_key[0]);
            cmp("busy_u2", bus2.busy,     e_busy[0]);
            cmp("done_u2", bus2.done,     e_done[0]);
            cmp("elem_u2", bus2.elemento, e_elem[0]);
            cmp("key_u1",  bus1.key,      e_key[1]);
            cmp("busy_u1", bus1.busy,     e_busy[1]);
            cmp("done_u1", bus1.done,     e_done[1]);
            cmp("elem_u1", bus1.elemento, e_elem[1]);
        end
    end

    task automatic set_ready(input int d, input logic v);
        if (d == 0) bus2.ready = v; else bus1.ready = v;
    endtask
    task automatic set_s1(input int d, input logic [4:0] v);
        if (d == 0) bus2.s1 = v; else bus1.s1 = v;
    endtask
    task automatic set_rst(input int d, input logic v);
        if (d == 0) rst2 = v; else rst1 = v;
    endtask

    // Caller has set ready=1 at a falling edge; cycle n is sampled at the n-th following falling edge.
    task automatic run_char(input int d, input int ncyc, input int drop_at, input int inj_at,
                            input int rst_at, output logic [63:0] keys, output int busy_cnt,
                            output int done_at, output int done_cnt);
        logic k, b, dn;
        keys = '0; busy_cnt = 0; done_at = 0; done_cnt = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n == drop_at) set_ready(d, 1'b0);
            if (inj_at > 0 && n == inj_at) begin set_ready(d, 1'b1); set_s1(d, 5'b00000); end
            if (inj_at > 0 && n == inj_at + 1) set_ready(d, 1'b0);
            if (rst_at > 0 && n == rst_at) set_rst(d, 1'b0);
            if (rst_at > 0 && n == rst_at + 1) set_rst(d, 1'b1);
            k  = (d == 0) ? bus2.key  : bus1.key;
            b  = (d == 0) ? bus2.busy : bus1.busy;
            dn = (d == 0) ? bus2.done : bus1.done;
            keys = {keys[62:0], k};
            if (b) busy_cnt++;
            if (dn) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
        end
    endtask

    logic [63:0] keys;
    logic [25:0] pat5;
    int busy_cnt, done_at, done_cnt;

    initial begin
        rst2 = 1'b0; rst1 = 1'b0;
        bus2.ready = 1'b1; bus1.ready = 1'b1;
        bus2.s1 = 5'b11111; bus1.s1 = 5'b11111;

        // Reset held with a pending request: nothing may start.
        repeat (3) begin
            @(negedge clk);
            cmp("rst_key", bus2.key, 1'b0);
            cmp("rst_busy", bus2.busy, 1'b0);
            cmp("rst_elem", bus2.elemento, 3'd0);
        end
        rst2 = 1'b1; rst1 = 1'b1;
        bus2.ready = 1'b0; bus1.ready = 1'b0;
        repeat (2) @(negedge clk);

        // Digit 5, U=2.
        bus2.s1 = 5'b00000; bus2.ready = 1'b1;
        run_char(0, 26, 1, 0, 0, keys, busy_cnt, done_at, done_cnt);
        pat5 = 26'b11001100110011001100000000;
        cmp("d5_keys", 32'(keys[25:0]), 32'(pat5));
        cmp("d5_busy", busy_cnt, 24);
        cmp("d5_done", done_at, 25);
        cmp("d5_model_T", t_len[0], 24);
        repeat (2) @(negedge clk);

        // Digit 0, U=2.
        bus2.s1 = 5'b11111; bus2.ready = 1'b1;
        run_char(0, 46, 1, 0, 0, keys, busy_cnt, done_at, done_cnt);
        cmp("d0_busy", busy_cnt, 44);
        cmp("d0_done", done_at, 45);
        cmp("d0_model_T", t_len[0], 44);
        repeat (2) @(negedge clk);

        // Digit 1, U=1, ready held: back-to-back capture in the done cycle.
        bus1.s1 = 5'b01111; bus1.ready = 1'b1;
        run_char(1, 45, 22, 0, 0, keys, busy_cnt, done_at, done_cnt);
        cmp("d1_done", done_at, 21);
        cmp("d1_key_c21", keys[24], 1'b0);
        cmp("d1_key_c22", keys[23], 1'b1);
        cmp("d1_done_cnt", done_cnt, 2);
        cmp("d1_busy", busy_cnt, 40);
        cmp("d1_model_T", t_len[1], 20);
        repeat (2) @(negedge clk);

        // Digit 9, U=2, extra request and s1 change mid-character.
        bus2.s1 = 5'b11110; bus2.ready = 1'b1;
        run_char(0, 50, 1, 10, 0, keys, busy_cnt, done_at, done_cnt);
        cmp("d9_done_cnt", done_cnt, 1);
        cmp("d9_busy", busy_cnt, 40);
        cmp("d9_done", done_at, 41);
        repeat (2) @(negedge clk);

        // Digit 0, U=2, reset asserted during cycle 10.
        bus2.s1 = 5'b11111; bus2.ready = 1'b1;
        run_char(0, 12, 1, 0, 10, keys, busy_cnt, done_at, done_cnt);
        cmp("rs_key_c10", keys[2], 1'b1);
        cmp("rs_key_c11", keys[1], 1'b0);
        cmp("rs_busy", busy_cnt, 10);
        cmp("rs_done_cnt", done_cnt, 0);
        bus2.ready = 1'b1;
        run_char(0, 46, 1, 0, 0, keys, busy_cnt, done_at, done_cnt);
        cmp("rs_after_busy", busy_cnt, 44);
        cmp("rs_after_done", done_at, 45);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
